// File: rtl/alu_pkg.sv
// Shared op-code and status-bit definitions for the pipelined ALU.
package alu_pkg;

    // Op codes; 000-011 are the original 2-bit ALU codes, zero-extended.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_NOTB = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SHL  = 3'b110;
    localparam logic [2:0] ALU_SHR  = 3'b111;

    // Bit positions inside the 4-bit {N, Z, C, V} status word.
    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-parametrised ALU with full N/Z/C/V status.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status
);

    logic             w_sub;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic             w_c;
    logic             w_v;

    // SUB shares the adder: a + ~b + 1, so C=1 means no borrow.
    assign w_sub = (op == ALU_SUB);
    assign w_bop = w_sub ? ~b : b;
    assign w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};

    // One guard bit on each shifter catches the last bit shifted out;
    // a zero shift amount leaves the guard bit at 0, giving C=0.
    assign w_amt = b[SHW-1:0];
    assign w_shl = {1'b0, a} << w_amt;
    assign w_shr = {a, 1'b0} >> w_amt;

    // Select the result, carry and overflow for the requested op.
    always_comb begin
        result = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result = w_sum[WIDTH-1:0];
                w_c    = w_sum[WIDTH];
                w_v    = (a[WIDTH-1] == w_bop[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  result = a & b;
            ALU_NOTB: result = ~b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SHL: begin
                result = w_shl[WIDTH-1:0];
                w_c    = w_shl[WIDTH];
            end
            ALU_SHR: begin
                result = w_shr[WIDTH:1];
                w_c    = w_shr[0];
            end
            default: ;
        endcase
    end

    assign status = {result[WIDTH-1], (result == '0), w_c, w_v};

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with sticky overflow flag.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       status,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int STAGES = 2;

    // Index 1 is S1 (operands), index 2 is S2 (result).
    logic [STAGES:1]  r_vld_pipe;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_status;
    logic             r_sticky;

    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_st;
    logic             w_s2_drain;
    logic             w_s1_adv;
    logic             w_accept;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_res),
        .status (w_st)
    );

    // S1 moves on when S2 is empty or emptying this cycle, so a full
    // pipe with out_ready=1 still accepts a new op without a bubble.
    assign w_s2_drain = r_vld_pipe[2] && out_ready;
    assign w_s1_adv   = r_vld_pipe[1] && (!r_vld_pipe[2] || w_s2_drain);
    assign in_ready   = !r_vld_pipe[1] || w_s1_adv;
    assign w_accept   = in_valid && in_ready;

    // Stage 1: capture operands and op on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe[1] <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= ALU_ADD;
        end else if (w_accept) begin
            r_vld_pipe[1] <= 1'b1;
            r_a           <= ain;
            r_b           <= bin;
            r_op          <= alu_op;
        end else if (w_s1_adv) begin
            r_vld_pipe[1] <= 1'b0;
        end
    end

    // Stage 2: register the ALU result; hold it while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe[2] <= 1'b0;
            r_out         <= '0;
            r_status      <= '0;
        end else if (w_s1_adv) begin
            r_vld_pipe[2] <= 1'b1;
            r_out         <= w_res;
            r_status      <= w_st;
        end else if (w_s2_drain) begin
            r_vld_pipe[2] <= 1'b0;
        end
    end

    // Sticky overflow: a delivered V=1 result wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
        end else if (w_s2_drain && r_status[ST_V]) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_valid  = r_vld_pipe[2];
    assign out        = r_out;
    assign status     = r_status;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with an arithmetic reference model and scoreboard.
module tb_alu_pipe;

    localparam int W   = 16;
    localparam int SHW = $clog2(W);

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_sticky = 1'b0;
    logic [W-1:0] ain = '0;
    logic [W-1:0] bin = '0;
    logic [2:0]   alu_op = '0;
    logic         in_ready;
    logic         out_valid;
    logic         ovf_sticky;
    logic [W-1:0] out;
    logic [3:0]   status;

    logic         v8 = 1'b0;
    logic         ordy8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic [2:0]   op8 = '0;
    logic         irdy8;
    logic         ovld8;
    logic         stk8;
    logic [7:0]   out8;
    logic [3:0]   st8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W+3:0] mq[$];
    logic         m_sticky = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ain(ain), .bin(bin), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .status(status),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(irdy8),
        .ain(a8), .bin(b8), .alu_op(op8), .out_valid(ovld8),
        .out_ready(ordy8), .out(out8), .status(st8),
        .ovf_sticky(stk8), .clr_sticky(1'b0)
    );

    // Reference: plain integer arithmetic, returns {result, N, Z, C, V}.
    function automatic logic [W+3:0] model(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint ua, ub, m, s, sa, sb, sv, r;
        int n;
        logic c, v;
        logic [W-1:0] res;
        m  = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - m : ua;
        sb = b[W-1] ? ub - m : ub;
        n  = int'(ub % (longint'(1) << SHW));
        c = 1'b0; v = 1'b0; r = 0; sv = 0;
        case (op)
            3'd0: begin s = ua + ub; r = s % m; c = (s >= m); sv = sa + sb;
                        v = (sv >= m / 2) || (sv < -(m / 2)); end
            3'd1: begin s = ua + (m - 1 - ub) + 1; r = s % m; c = (s >= m); sv = sa - sb;
                        v = (sv >= m / 2) || (sv < -(m / 2)); end
            3'd2: r = ua & ub;
            3'd3: r = (m - 1) & ~ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: begin r = (ua << n) % m;
                        c = (n > 0 && n <= W) ? (((ua >> (W - n)) & 1) != 0) : 1'b0; end
            default: begin r = ua >> n;
                        c = (n > 0) ? (((ua >> (n - 1)) & 1) != 0) : 1'b0; end
        endcase
        res = r[W-1:0];
        return {res, res[W-1], (res == '0), c, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every presented result must match the oldest expected one.
    always @(negedge clk) begin
        logic [W+3:0] e;
        logic dv;
        if (reset_n) begin
            chk("sticky_model", {31'd0, ovf_sticky}, {31'd0, m_sticky});
            dv = 1'b0;
            if (out_valid) begin
                if (mq.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = mq[0];
                    chk("sb_out", {16'd0, out}, {16'd0, e[W+3:4]});
                    chk("sb_status", {28'd0, status}, {28'd0, e[3:0]});
                    if (out_ready) begin
                        dv = e[0];
                        void'(mq.pop_front());
                    end
                end
            end
            if (dv) m_sticky = 1'b1;
            else if (clr_sticky) m_sticky = 1'b0;
            if (in_valid && in_ready) mq.push_back(model(alu_op, ain, bin));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        acc = 1'b0;
        alu_op = op; ain = a; bin = b; in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic op1(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eo, input logic [3:0] es);
        send(op, a, b);
        tick();
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_out"}, {16'd0, out}, {16'd0, eo});
        chk({name, "_status"}, {28'd0, status}, {28'd0, es});
        tick();
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_status", {28'd0, status}, 32'd0);
        chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        #11 reset_n = 1'b1;
        tick();
        out_ready = 1'b1;

        op1("add",   3'd0, 16'd31, 16'd11, 16'h002A, 4'b0000);
        op1("sub",   3'd1, 16'd31, 16'd11, 16'h0014, 4'b0010);
        op1("sub_z", 3'd1, 16'd5,  16'd5,  16'h0000, 4'b0110);
        op1("ovf",   3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
        chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);
        send(3'd0, 16'h7FFF, 16'h0001);
        tick();
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        chk("sticky_prio", {31'd0, ovf_sticky}, 32'd1);

        op1("and",    3'd2, 16'd31,   16'd11,   16'h000B, 4'b0000);
        op1("notb",   3'd3, 16'd0,    16'd11,   16'hFFF4, 4'b1000);
        op1("or",     3'd4, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
        op1("xor_z",  3'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100);
        op1("shl1",   3'd6, 16'h8001, 16'd1,    16'h0002, 4'b0010);
        op1("shl0",   3'd6, 16'h8001, 16'd0,    16'h8001, 4'b1000);
        op1("shl15",  3'd6, 16'h0003, 16'd15,   16'h8000, 4'b1010);
        op1("shr1",   3'd7, 16'h0003, 16'd1,    16'h0001, 4'b0010);
        op1("shr15",  3'd7, 16'h8000, 16'd15,   16'h0001, 4'b0000);

        // Backpressure: three back-to-back ops against a stalled consumer.
        out_ready = 1'b0;
        alu_op = 3'd0; ain = 16'd1; bin = 16'd2; in_valid = 1'b1;
        @(negedge clk); chk("bp_rdy0", {31'd0, in_ready}, 32'd1); tick();
        alu_op = 3'd1; ain = 16'd10; bin = 16'd3;
        @(negedge clk); chk("bp_rdy1", {31'd0, in_ready}, 32'd1); tick();
        alu_op = 3'd5; ain = 16'hF0F0; bin = 16'h0FF0;
        @(negedge clk); chk("bp_full", {31'd0, in_ready}, 32'd0);
        chk("bp_vld", {31'd0, out_valid}, 32'd1); tick();
        @(negedge clk); chk("bp_full2", {31'd0, in_ready}, 32'd0);
        chk("bp_hold", {16'd0, out}, 32'h0003); tick();
        out_ready = 1'b1;
        chk("bp_head", {16'd0, out}, 32'h0003);
        tick(); in_valid = 1'b0;
        chk("bp_2nd_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_2nd", {16'd0, out}, 32'h0007);
        tick();
        chk("bp_3rd_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_3rd", {16'd0, out}, 32'hFF00);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-flight with two entries held.
        out_ready = 1'b0;
        send(3'd0, 16'd1, 16'd1);
        send(3'd0, 16'd7, 16'd8);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_stk", {31'd0, ovf_sticky}, 32'd0);
        mq.delete();
        m_sticky = 1'b0;
        alu_op = 3'd0; ain = 16'd2; bin = 16'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1 reset_n = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        chk("post_rst_vld", {31'd0, out_valid}, 32'd1);
        chk("post_rst_out", {16'd0, out}, 32'h0004);
        repeat (3) tick();
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

        // Narrow instance.
        op8 = 3'd0; a8 = 8'h7F; b8 = 8'h01; v8 = 1'b1; ordy8 = 1'b1;
        tick(); v8 = 1'b0;
        for (int i = 0; i < 10 && !ovld8; i++) tick();
        chk("w8_vld", {31'd0, ovld8}, 32'd1);
        chk("w8_out", {24'd0, out8}, 32'h80);
        chk("w8_status", {28'd0, st8}, 32'b1001);
        tick();
        chk("w8_sticky", {31'd0, stk8}, 32'd1);

        chk("sb_drained", mq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Pipelined, parametrised successor to the 16-bit combinational ALU. Accepts one operation per cycle over a valid/ready handshake, computes it in a two-stage registered pipeline, and returns the result with a full N/Z/C/V status word plus a sticky overflow flag. It sits between the register-file read ports and the writeback mux of the datapath and lets the controller stall on writeback without losing operations.

## Interface
- `WIDTH`, default 16: operand and result width; must be at least 4.
- `SHW`, default $clog2(WIDTH): number of shift-amount bits taken from `bin`.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an operation is presented on `ain`, `bin`, `alu_op`.
- `in_ready` out 1: the block accepts the operation this cycle.
- `ain` in WIDTH: operand A.
- `bin` in WIDTH: operand B.
- `alu_op` in 3: operation code (see Operation).
- `out_valid` out 1: `out` and `status` hold a result.
- `out_ready` in 1: the consumer takes the result this cycle.
- `out` out WIDTH: result.
- `status` out 4: {N, Z, C, V} for the result on `out`.
- `ovf_sticky` out 1: set by any delivered result with V=1.
- `clr_sticky` in 1: synchronous clear of `ovf_sticky`.

## Operation
- Op codes: 000 ADD (a+b), 001 SUB (a+~b+1), 010 AND, 011 NOTB (~b), 100 OR, 101 XOR, 110 SHL (a << b[SHW-1:0]), 111 SHR (logical, a >> b[SHW-1:0]). Codes 000–011 match the original 2-bit ALU, zero-extended.
- N = out[WIDTH-1]. Z = (out == 0) for every op.
- C: ADD and SUB use the carry out of the WIDTH-bit sum. For SUB, C=1 means no borrow. SHL uses the last bit shifted out of the MSB. SHR uses the last bit shifted out of the LSB. A shift amount of 0 gives C=0. Logic ops give C=0.
- V: ADD and SUB give two's-complement overflow. All other ops give V=0.
- Stage 1 (S1) registers the operands and op. Stage 2 (S2) registers `out` and `status`, which are computed combinationally from S1.
- Each stage holds one entry. A stage advances when the stage after it is empty or is draining in the same cycle.
- `in_ready` = !S1.valid || (S1 advances this cycle).
- S2 drains when `out_valid && out_ready`.
- `ovf_sticky` sets when a result with V=1 is delivered (the handshake completes). It clears on `clr_sticky`. Set has priority over clear in the same cycle.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `out`=0, `status`=0, `ovf_sticky`=0, and both stage valids are 0.
- Latency is 2 cycles. An operation accepted at edge k is presented with `out_valid`=1 after edge k+1.
- Throughput is one operation per cycle while `out_ready`=1.
- Backpressure: with `out_ready`=0 the pipe holds at most 2 entries, and `in_ready` drops once both stages are full.
- A full pipe with `out_ready`=1 and `in_valid`=1 accepts a new operation and delivers one in the same cycle, so there is no bubble.
- `out` and `status` stay stable while `out_valid && !out_ready`.
- The producer must hold `ain`/`bin`/`alu_op` stable while `in_valid && !in_ready`.
- Asserting `reset_n` mid-operation discards all in-flight entries immediately, without waiting for a clock edge. The first accept after release is at the first rising edge with `reset_n`=1.
- Results are delivered strictly in order. None are dropped or duplicated.

## Structure
- Package `alu_pkg`:
  - op-code localparams (`ALU_ADD` … `ALU_SHR`);
  - status bit indices (`ST_N`=3, `ST_Z`=2, `ST_C`=1, `ST_V`=0).
- Sub-module `alu_core`: a combinational, WIDTH-parametrised next generation of the original ALU. Inputs are a, b, op; outputs are result and the 4-bit status.
- `alu_pipe` contains only the two stage registers, the handshake logic and the sticky flag.

## Test plan
- ADD: 16'd31 + 16'd11 with `out_ready`=1 -> `out`=16'h002A and `status`=0000, two cycles after the accept.
- SUB: 31−11 -> 16'h0014 and `status`=0010 (C=1). Then 5−5 -> 16'h0000 and `status`=0110.
- Overflow and sticky:
  - 16'h7FFF + 16'h0001 -> 16'h8000, `status`=1001, and `ovf_sticky` rises on delivery.
  - `clr_sticky` pulsed alone -> `ovf_sticky`=0.
  - `clr_sticky` pulsed while another V=1 result is delivered -> `ovf_sticky` stays 1.
- Logic and shifts:
  - AND 31,11 -> 16'h000B.
  - NOTB 11 -> 16'hFFF4 with N=1.
  - SHL 16'h8001 by 1 -> 16'h0002 with C=1.
  - SHR 16'h0003 by 1 -> 16'h0001 with C=1.
- Backpressure: hold `out_ready`=0 and offer 3 back-to-back ops.
  - Only 2 are accepted, and `in_ready`=0 from the cycle after the second accept.
  - Then raise `out_ready` -> all 3 results emerge in order, one per cycle, with no bubbles.
- Reset: with 2 entries in flight, pulse `reset_n` low between edges -> `out_valid` falls immediately and `in_ready`=1. Neither old result appears after release. `WIDTH`=8 instance regressed with 8'h7F + 8'h01 -> 8'h80 and V=1.
